json_scan_ctrl: RTL and testbench

Streaming structural controller for the JSON decode datapath. Consumes a byte stream one character per cycle and tracks string and escape state, with a container stack of up to MAX_DEPTH nested objects and arrays. Emits one registered structural event per significant byte, and flags malformed structure (mismatched or unbalanced brackets, depth overflow, premature EOF, trailing characters). Sits in front of the value decoder, sequencing it with open/close/string boundaries so scalar parsing never has to track nesting.

---
 rtl/json_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_json_scan_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/json_scan_ctrl.sv
// rtl/json_scan_ctrl.sv - streaming JSON structural scanner with a container stack and error flagging
// Define JSON_SCAN_POS_EN to report byte offsets on evt_pos; otherwise evt_pos is tied to 0.
module json_scan_ctrl #(
   parameter int MAX_DEPTH = 16,
   parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1),
   parameter int POS_W     = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_data,
   input  logic               in_last,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [2:0]         evt_kind,
   output logic               evt_last,
   output logic [DEPTH_W-1:0] evt_depth,
   output logic [2:0]         evt_err,
   output logic [POS_W-1:0]   evt_pos
);

   typedef enum logic [2:0] {
      S_VALUE    = 3'd0,
      S_STRING   = 3'd1,
      S_ESCAPE   = 3'd2,
      S_TOP_DONE = 3'd3,
      S_ERROR    = 3'd4
   } state_t;

   localparam logic [2:0] K_OBJ_OPEN  = 3'd0;
   localparam logic [2:0] K_OBJ_CLOSE = 3'd1;
   localparam logic [2:0] K_ARR_OPEN  = 3'd2;
   localparam logic [2:0] K_ARR_CLOSE = 3'd3;
   localparam logic [2:0] K_STR_OPEN  = 3'd4;
   localparam logic [2:0] K_STR_CLOSE = 3'd5;
   localparam logic [2:0] K_DOC_END   = 3'd6;
   localparam logic [2:0] K_ERROR     = 3'd7;

   localparam logic [2:0] E_NONE     = 3'd0;
   localparam logic [2:0] E_TOKEN    = 3'd1;
   localparam logic [2:0] E_DEPTH    = 3'd2;
   localparam logic [2:0] E_EOF_STR  = 3'd3;
   localparam logic [2:0] E_EOF_CONT = 3'd4;
   localparam logic [2:0] E_TRAILING = 3'd5;
   localparam logic [2:0] E_CTRL     = 3'd6;

   localparam logic [DEPTH_W-1:0]   D_ONE   = 1;
   localparam logic [DEPTH_W-1:0]   D_MAX   = DEPTH_W'(MAX_DEPTH);
   localparam logic [MAX_DEPTH-1:0] STK_ONE = 1;

   state_t               state, state_nxt;
   logic [DEPTH_W-1:0]   depth, depth_nxt;
   logic [MAX_DEPTH-1:0] stack, stack_nxt;
   logic                 accept;
   logic                 ev_gen;
   logic [2:0]           ev_kind;
   logic [2:0]           ev_err;
   logic                 is_open, is_close, is_arr, is_quote, is_bslash, is_ws, is_ctrl;
   logic                 top_is_arr;

   assign accept    = in_valid && in_ready;
   assign is_open   = (in_data == 8'h7B) || (in_data == 8'h5B);
   assign is_close  = (in_data == 8'h7D) || (in_data == 8'h5D);
   assign is_arr    = (in_data == 8'h5B) || (in_data == 8'h5D);
   assign is_quote  = (in_data == 8'h22);
   assign is_bslash = (in_data == 8'h5C);
   assign is_ctrl   = (in_data < 8'h20);
   assign is_ws     = (in_data == 8'h20) || (in_data == 8'h09) ||
                      (in_data == 8'h0A) || (in_data == 8'h0D);

   // Stack bit (depth-1) holds the innermost container type; only meaningful when depth != 0.
   assign top_is_arr = |(stack & (STK_ONE << (depth - D_ONE)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_VALUE;
         depth <= '0;
         stack <= '0;
      end else if (accept) begin
         state <= state_nxt;
         depth <= depth_nxt;
         stack <= stack_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      depth_nxt = depth;
      stack_nxt = stack;
      ev_gen    = 1'b0;
      ev_kind   = K_DOC_END;
      ev_err    = E_NONE;

      case (state)
         S_VALUE: begin
            if (is_open) begin
               if (depth == D_MAX) begin
                  ev_err = E_DEPTH;
               end else begin
                  stack_nxt = is_arr ? (stack | (STK_ONE << depth)) : (stack & ~(STK_ONE << depth));
                  depth_nxt = depth + D_ONE;
                  ev_gen    = 1'b1;
                  ev_kind   = is_arr ? K_ARR_OPEN : K_OBJ_OPEN;
               end
            end else if (is_close) begin
               if ((depth == '0) || (top_is_arr != is_arr)) begin
                  ev_err = E_TOKEN;
               end else begin
                  depth_nxt = depth - D_ONE;
                  ev_gen    = 1'b1;
                  ev_kind   = is_arr ? K_ARR_CLOSE : K_OBJ_CLOSE;
                  if (depth == D_ONE) state_nxt = S_TOP_DONE;
               end
            end else if (is_quote) begin
               ev_gen    = 1'b1;
               ev_kind   = K_STR_OPEN;
               state_nxt = S_STRING;
            end
         end
         S_STRING: begin
            if (is_bslash) begin
               state_nxt = S_ESCAPE;
            end else if (is_quote) begin
               ev_gen    = 1'b1;
               ev_kind   = K_STR_CLOSE;
               state_nxt = (depth == '0) ? S_TOP_DONE : S_VALUE;
            end else if (is_ctrl) begin
               ev_err = E_CTRL;
            end
         end
         S_ESCAPE: state_nxt = S_STRING;
         S_TOP_DONE: begin
            if (!is_ws) ev_err = E_TRAILING;
         end
         default: ;
      endcase

      // End of document is judged on the state the byte leaves behind.
      if ((ev_err == E_NONE) && in_last) begin
         if ((state_nxt == S_STRING) || (state_nxt == S_ESCAPE)) begin
            ev_err = E_EOF_STR;
         end else if (depth_nxt != '0) begin
            ev_err = E_EOF_CONT;
         end else begin
            if (!ev_gen) begin
               ev_gen  = 1'b1;
               ev_kind = K_DOC_END;
            end
            state_nxt = S_VALUE;
            depth_nxt = '0;
            stack_nxt = '0;
         end
      end

      if (ev_err != E_NONE) begin
         ev_gen    = 1'b1;
         ev_kind   = K_ERROR;
         state_nxt = S_ERROR;
         depth_nxt = depth;
         stack_nxt = stack;
      end
   end

   always_comb begin
      in_ready = (state != S_ERROR) && (!evt_valid || evt_ready);
   end

   // An error event reports the pre-byte depth, which depth_nxt carries on that path.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_valid <= 1'b0;
         evt_kind  <= 3'd0;
         evt_last  <= 1'b0;
         evt_depth <= '0;
         evt_err   <= 3'd0;
      end else if (accept && ev_gen) begin
         evt_valid <= 1'b1;
         evt_kind  <= ev_kind;
         evt_last  <= in_last;
         evt_depth <= depth_nxt;
         evt_err   <= ev_err;
      end else if (evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

`ifdef JSON_SCAN_POS_EN
   logic [POS_W-1:0] pos;
   logic [POS_W-1:0] evt_pos_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         pos       <= '0;
         evt_pos_r <= '0;
      end else if (accept) begin
         if (in_last) pos <= '0;
         else if (pos != '1) pos <= pos + POS_W'(1);
         if (ev_gen) evt_pos_r <= pos;
      end
   end

   assign evt_pos = evt_pos_r;
`else
   assign evt_pos = '0;
`endif

endmodule

// File: tb/tb_json_scan_ctrl.sv
// tb/tb_json_scan_ctrl.sv - randomized self-checking bench for json_scan_ctrl against a queue-based model
// Expected evt_pos follows JSON_SCAN_POS_EN when the bench is built with it.
module tb_json_scan_ctrl;

   localparam int TB_DEPTH = 4;
   localparam int DW = $clog2(TB_DEPTH + 1);
`ifdef JSON_SCAN_POS_EN
   localparam bit POS_EN = 1'b1;
`else
   localparam bit POS_EN = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [2:0]  kind;
      logic        last;
      logic [7:0]  depth;
      logic [2:0]  err;
      logic [31:0] pos;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          evt_ready = 1'b1;
   logic          in_ready, evt_valid, evt_last;
   logic [2:0]    evt_kind, evt_err;
   logic [DW-1:0] evt_depth;
   logic [31:0]   evt_pos;

   int  n_checks = 0;
   int  n_errors = 0;
   int  ready_mode = 1;
   bit  in_rst = 1'b1;

   // Reference model: mode 0 value, 1 string, 2 escape, 3 top done, 4 error.
   int  mode = 0;
   int  pos = 0;
   bit  stk[$];
   ev_t exp_q[$];

   always #5 clk = ~clk;

   json_scan_ctrl #(.MAX_DEPTH(TB_DEPTH), .POS_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_kind(evt_kind), .evt_last(evt_last),
      .evt_depth(evt_depth), .evt_err(evt_err), .evt_pos(evt_pos)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_ev(input int kind, input logic last, input int depth, input int err);
      ev_t e;
      e.kind  = 3'(kind);
      e.last  = last;
      e.depth = 8'(depth);
      e.err   = 3'(err);
      e.pos   = POS_EN ? 32'(pos) : 32'd0;
      exp_q.push_back(e);
   endtask

   task automatic model_byte(input logic [7:0] c, input logic l);
      int  k = -1;
      int  err = 0;
      int  d0 = stk.size();
      int  m = mode;
      bit  a;
      case (mode)
         0: begin
            if (c == 8'h7B || c == 8'h5B) begin
               if (stk.size() == TB_DEPTH) err = 2;
               else begin
                  a = (c == 8'h5B);
                  stk.push_back(a);
                  k = a ? 2 : 0;
               end
            end else if (c == 8'h7D || c == 8'h5D) begin
               a = (c == 8'h5D);
               if (stk.size() == 0 || stk[$] != a) err = 1;
               else begin
                  void'(stk.pop_back());
                  k = a ? 3 : 1;
                  if (stk.size() == 0) m = 3;
               end
            end else if (c == 8'h22) begin
               k = 4;
               m = 1;
            end
         end
         1: begin
            if (c == 8'h5C) m = 2;
            else if (c == 8'h22) begin
               k = 5;
               m = (stk.size() == 0) ? 3 : 0;
            end else if (c < 8'h20) err = 6;
         end
         2: m = 1;
         3: if (!(c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D)) err = 5;
         default: ;
      endcase
      if (err == 0 && l) begin
         if (m == 1 || m == 2) err = 3;
         else if (stk.size() != 0) err = 4;
         else if (k < 0) k = 6;
      end
      if (err != 0) begin
         push_ev(7, l, d0, err);
         mode = 4;
      end else begin
         if (k >= 0) push_ev(k, l, stk.size(), 0);
         mode = m;
      end
      if (l) begin
         pos = 0;
         if (err == 0) begin
            stk.delete();
            mode = 0;
         end
      end else pos++;
   endtask

   task automatic do_reset();
      in_rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      stk.delete();
      mode = 0;
      pos = 0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_kind", evt_kind, 0);
      check("rst_evt_last", evt_last, 0);
      check("rst_evt_depth", evt_depth, 0);
      check("rst_evt_err", evt_err, 0);
      check("rst_evt_pos", evt_pos, 0);
      in_rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] c, input logic l);
      int t = 0;
      in_valid = 1'b1;
      in_data = c;
      in_last = l;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            model_byte(c, l);
            break;
         end
         t++;
         if (t > 200) begin
            check("accept_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
      check("drain_pending", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_q(input bq_t q, input bit with_last);
      for (int i = 0; i < q.size(); i++) begin
         if (mode == 4) break;
         send_byte(q[i], with_last && (i == q.size() - 1));
      end
      if (mode == 4) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ready_after_err", in_ready, 0);
         end
         @(posedge clk);
         #1;
      end
      drain();
      if (mode == 4) do_reset();
   endtask

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   task automatic run(input string s, input bit with_last);
      run_q(str2q(s), with_last);
   endtask

   function automatic string gen_valid();
      string s;
      bit    t[$];
      bit    a;
      int    r;
      if ($urandom_range(4) == 0) return "\"top\\\"s\" \t";
      a = 1'($urandom_range(1));
      t.push_back(a);
      if (a) s = "["; else s = "{";
      for (int k = 0; k < 10; k++) begin
         r = $urandom_range(4);
         if (r == 0 && t.size() < TB_DEPTH) begin
            a = 1'($urandom_range(1));
            t.push_back(a);
            if (a) s = {s, "["}; else s = {s, "{"};
         end else if (r == 1 && t.size() > 1) begin
            if (t[$]) s = {s, "]"}; else s = {s, "}"};
            void'(t.pop_back());
         end else if (r == 2) begin
            case ($urandom_range(2))
               0: s = {s, "\"k\":"};
               1: s = {s, "\"a\\\\b\""};
               default: s = {s, "\"q\\\"]{\""};
            endcase
         end else s = {s, "1, "};
      end
      while (t.size() > 0) begin
         if (t[$]) s = {s, "]"}; else s = {s, "}"};
         void'(t.pop_back());
      end
      if ($urandom_range(1) == 1) s = {s, " \n"};
      return s;
   endfunction

   function automatic bq_t gen_garbage();
      logic [7:0] alpha [12] = '{8'h7B, 8'h7D, 8'h5B, 8'h5D, 8'h22, 8'h5C,
                                 8'h61, 8'h20, 8'h09, 8'h31, 8'h01, 8'h0A};
      bq_t q;
      int  n = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) q.push_back(alpha[$urandom_range(11)]);
      return q;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0: evt_ready = ($urandom_range(3) != 0);
            1: evt_ready = 1'b1;
            default: evt_ready = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      ev_t e;
      ev_t held;
      bit  stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (in_rst) stalled = 1'b0;
         else begin
            if (stalled) begin
               check("hold_valid", evt_valid, 1);
               check("hold_kind", evt_kind, held.kind);
               check("hold_last", evt_last, held.last);
               check("hold_depth", evt_depth, held.depth);
               check("hold_err", evt_err, held.err);
               check("hold_pos", evt_pos, held.pos);
            end
            if (evt_valid && evt_ready) begin
               if (exp_q.size() == 0) check("spurious_evt", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("evt_kind", evt_kind, e.kind);
                  check("evt_last", evt_last, e.last);
                  check("evt_depth", evt_depth, e.depth);
                  check("evt_err", evt_err, e.err);
                  check("evt_pos", evt_pos, e.pos);
               end
               stalled = 1'b0;
            end else if (evt_valid) begin
               stalled = 1'b1;
               held.kind  = evt_kind;
               held.last  = evt_last;
               held.depth = 8'(evt_depth);
               held.err   = evt_err;
               held.pos   = evt_pos;
            end else stalled = 1'b0;
         end
      end
   end

   initial begin
      do_reset();
      ready_mode = 1;
      run("{\"a\":[1,2]}", 1'b1);
      run("[\"x\\\"]\"]", 1'b1);
      run("[[[[[", 1'b1);
      run("[}", 1'b1);
      run("{}x", 1'b1);
      run("{\"ab", 1'b1);
      run("[[]", 1'b1);

      // Backpressure: OBJ_OPEN must stay held and no byte may slip in.
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send_byte(8'h7B, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_evt_valid", evt_valid, 1);
      end
      ready_mode = 1;
      send_byte(8'h7D, 1'b1);
      drain();

      ready_mode = 0;
      run("[[", 1'b0);
      do_reset();
      run("[]", 1'b1);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(2) == 0) run_q(gen_garbage(), 1'b1);
         else run(gen_valid(), 1'b1);
      end

      ready_mode = 1;
      drain();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
